// File: rtl/tile_fetch_collector_pkg.sv
// Shared definitions for the tile fetch/write/collect datapath.
// Bank-state encodings are common to the fetch, write and collect blocks.
// Helpers here are pure functions with no state.
package tile_fetch_collector_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'b00,
    BANK_FILLING = 2'b01,
    BANK_FULL    = 2'b10
  } bank_state_t;

  // Width of one assembled tile in bits.
  function automatic int tile_width(input int num_words, input int word_width);
    return num_words * word_width;
  endfunction

endpackage

// File: rtl/tile_fetch_collector_if.sv
// Bus between BRAM/fetch side, collector and tile consumer.
// master = collector side, slave = environment (BRAM + consumer).
// tile_valid/tile_ready is a plain valid/ready handshake.
interface tile_fetch_collector_if
  import tile_fetch_collector_pkg::*;
#(
  parameter int NUM_FETCHES_PER_TILE = 2,
  parameter int DATA_WIDTH           = 32,
  parameter int CNT_WIDTH            = 16
);
  localparam int TILE_W = tile_width(NUM_FETCHES_PER_TILE, DATA_WIDTH);

  logic                  bram_en;
  logic [DATA_WIDTH-1:0] bram_rdata;
  logic                  fill_ready;
  logic                  tile_valid;
  logic                  tile_ready;
  logic [TILE_W-1:0]     tile_data;
  logic [CNT_WIDTH-1:0]  tile_count;
  logic                  overflow_err;

  modport master (
    input  bram_en, bram_rdata, tile_ready,
    output fill_ready, tile_valid, tile_data, tile_count, overflow_err
  );

  modport slave (
    output bram_en, bram_rdata, tile_ready,
    input  fill_ready, tile_valid, tile_data, tile_count, overflow_err
  );

endinterface

// File: rtl/tile_fetch_collector_rd_latency_pipe.sv
// Delays the BRAM read strobe to line up with returned read data.
// Latency: READ_LATENCY cycles from en to word_vld.
// No backpressure; busy flags any strobe still in flight.
module rd_latency_pipe
  import tile_fetch_collector_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic en,
  output logic word_vld,
  output logic busy
);

  logic [READ_LATENCY-1:0] sr;

  // Shift the strobe one stage per cycle; reset/flush drops in-flight reads.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      sr <= '0;
    end else begin
      sr[0] <= en;
      for (int i = 1; i < READ_LATENCY; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign word_vld = sr[READ_LATENCY-1];
  assign busy     = |sr;

endmodule

// File: rtl/tile_fetch_collector.sv
// Assembles NUM_FETCHES_PER_TILE BRAM words into a tile using two ping-pong banks.
// Latency: tile_valid READ_LATENCY+1 cycles after the last bram_en.
// Backpressure: tile_ready low holds the tile; words with no free bank are dropped and flagged.
module tile_fetch_collector
  import tile_fetch_collector_pkg::*;
#(
  parameter int NUM_FETCHES_PER_TILE = 2,
  parameter int DATA_WIDTH           = 32,
  parameter int READ_LATENCY         = 1,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  tile_fetch_collector_if.master  bus
);

  localparam int TILE_W = tile_width(NUM_FETCHES_PER_TILE, DATA_WIDTH);
  localparam int WC_W   = (NUM_FETCHES_PER_TILE > 1) ? $clog2(NUM_FETCHES_PER_TILE) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NUM_FETCHES_PER_TILE - 1);

  logic word_vld;
  logic pipe_busy;

  rd_latency_pipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_latency_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .en       (bus.bram_en),
    .word_vld (word_vld),
    .busy     (pipe_busy)
  );

  // Registered state.
  bank_state_t           bank_q   [2];
  logic [TILE_W-1:0]     data_q   [2];
  logic                  fill_ptr;
  logic                  rd_ptr;
  logic [WC_W-1:0]       word_cnt;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  ovf_q;
  logic                  valid_q;

  // Next-state values.
  bank_state_t           bank_nxt [2];
  logic [TILE_W-1:0]     data_nxt [2];
  logic                  fill_nxt;
  logic                  rd_nxt;
  logic [WC_W-1:0]       cnt_nxt;
  logic [CNT_WIDTH-1:0]  count_nxt;
  logic                  ovf_nxt;
  logic                  hs;

  // Handshake frees the read bank while capture independently fills the other one.
  always_comb begin
    bank_nxt  = bank_q;
    data_nxt  = data_q;
    fill_nxt  = fill_ptr;
    rd_nxt    = rd_ptr;
    cnt_nxt   = word_cnt;
    count_nxt = count_q;
    ovf_nxt   = ovf_q;
    hs        = valid_q && bus.tile_ready;

    if (hs) begin
      bank_nxt[rd_ptr] = BANK_EMPTY;
      rd_nxt           = ~rd_ptr;
      count_nxt        = count_q + CNT_WIDTH'(1);
    end

    // Fullness is judged on the current state, so a word racing a handshake
    // on the same bank is still treated as overflow.
    if (word_vld) begin
      if (bank_q[fill_ptr] == BANK_FULL) begin
        ovf_nxt = 1'b1;
      end else begin
        data_nxt[fill_ptr][word_cnt*DATA_WIDTH +: DATA_WIDTH] = bus.bram_rdata;
        if (word_cnt == LAST_WORD) begin
          bank_nxt[fill_ptr] = BANK_FULL;
          cnt_nxt            = '0;
          fill_nxt           = ~fill_ptr;
        end else begin
          bank_nxt[fill_ptr] = BANK_FILLING;
          cnt_nxt            = word_cnt + WC_W'(1);
        end
      end
    end
  end

  // State registers; flush has the same effect as reset.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      bank_q[0] <= BANK_EMPTY;
      bank_q[1] <= BANK_EMPTY;
      data_q[0] <= '0;
      data_q[1] <= '0;
      fill_ptr  <= 1'b0;
      rd_ptr    <= 1'b0;
      word_cnt  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      bank_q    <= bank_nxt;
      data_q    <= data_nxt;
      fill_ptr  <= fill_nxt;
      rd_ptr    <= rd_nxt;
      word_cnt  <= cnt_nxt;
      count_q   <= count_nxt;
      ovf_q     <= ovf_nxt;
      valid_q   <= (bank_nxt[rd_nxt] == BANK_FULL);
    end
  end

  assign bus.tile_valid   = valid_q;
  assign bus.tile_data    = data_q[rd_ptr];
  assign bus.tile_count   = count_q;
  assign bus.overflow_err = ovf_q;
  assign bus.fill_ready   = (bank_q[fill_ptr] == BANK_EMPTY) && (word_cnt == '0) && !pipe_busy;

endmodule

// File: tb/tb_tile_fetch_collector.sv
// Directed bench for tile_fetch_collector: default build (dut_a) and READ_LATENCY=3 build (dut_b).
// Stimulus is driven #1 after posedge; outputs are checked at the same point.
// Expected values are hand-computed constants.
module tb_tile_fetch_collector;

  logic clk;
  logic rst_n;
  logic flush_a;
  logic flush_b;
  logic [31:0] rd_word;
  logic [31:0] dly [3];
  int n_chk;
  int n_pass;

  tile_fetch_collector_if #(.NUM_FETCHES_PER_TILE(2), .DATA_WIDTH(32), .CNT_WIDTH(16)) bus_a ();
  tile_fetch_collector_if #(.NUM_FETCHES_PER_TILE(2), .DATA_WIDTH(32), .CNT_WIDTH(16)) bus_b ();

  tile_fetch_collector #(.NUM_FETCHES_PER_TILE(2), .DATA_WIDTH(32), .READ_LATENCY(1), .CNT_WIDTH(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_a),
    .bus   (bus_a)
  );

  tile_fetch_collector #(.NUM_FETCHES_PER_TILE(2), .DATA_WIDTH(32), .READ_LATENCY(3), .CNT_WIDTH(16)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: the word presented with bram_en returns 1 or 3 cycles later.
  always @(posedge clk) begin
    dly[0] <= rd_word;
    dly[1] <= dly[0];
    dly[2] <= dly[1];
  end
  assign bus_a.bram_rdata = dly[0];
  assign bus_b.bram_rdata = dly[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial begin
    logic [31:0] pp [4];
    logic [31:0] ov [5];
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    flush_a = 1'b0;
    flush_b = 1'b0;
    rd_word = '0;
    bus_a.bram_en = 1'b0;
    bus_a.tile_ready = 1'b0;
    bus_b.bram_en = 1'b0;
    bus_b.tile_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 64'(bus_a.tile_valid), 64'd0);
    check("rst_fill_ready", 64'(bus_a.fill_ready), 64'd1);
    check("rst_count", 64'(bus_a.tile_count), 64'd0);
    check("rst_ovf", 64'(bus_a.overflow_err), 64'd0);
    check("rst_data", bus_a.tile_data, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single tile.
    bus_a.bram_en = 1'b1; rd_word = 32'hA1;
    tick();
    check("t1_fill_ready_busy", 64'(bus_a.fill_ready), 64'd0);
    rd_word = 32'hB2;
    tick();
    check("t1_valid_early", 64'(bus_a.tile_valid), 64'd0);
    bus_a.bram_en = 1'b0;
    tick();
    check("t1_valid", 64'(bus_a.tile_valid), 64'd1);
    check("t1_data", bus_a.tile_data, 64'h000000B2_000000A1);
    check("t1_fill_ready", 64'(bus_a.fill_ready), 64'd1);
    bus_a.tile_ready = 1'b1;
    tick();
    bus_a.tile_ready = 1'b0;
    check("t1_valid_after", 64'(bus_a.tile_valid), 64'd0);
    check("t1_count", 64'(bus_a.tile_count), 64'd1);
    check("t1_fill_ready_after", 64'(bus_a.fill_ready), 64'd1);

    // Ping-pong with backpressure.
    pp = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      bus_a.bram_en = 1'b1; rd_word = pp[i];
      tick();
    end
    bus_a.bram_en = 1'b0;
    tick();
    check("pp_valid", 64'(bus_a.tile_valid), 64'd1);
    check("pp_data0", bus_a.tile_data, 64'h00000022_00000011);
    check("pp_fill_ready", 64'(bus_a.fill_ready), 64'd0);
    tick();
    check("pp_hold_data", bus_a.tile_data, 64'h00000022_00000011);
    bus_a.tile_ready = 1'b1;
    tick();
    check("pp_b2b_valid", 64'(bus_a.tile_valid), 64'd1);
    check("pp_data1", bus_a.tile_data, 64'h00000044_00000033);
    check("pp_count1", 64'(bus_a.tile_count), 64'd2);
    tick();
    bus_a.tile_ready = 1'b0;
    check("pp_drained", 64'(bus_a.tile_valid), 64'd0);
    check("pp_count2", 64'(bus_a.tile_count), 64'd3);

    // Overflow: fifth word finds both banks full.
    ov = '{32'h01, 32'h02, 32'h03, 32'h04, 32'h99};
    for (int i = 0; i < 5; i++) begin
      bus_a.bram_en = 1'b1; rd_word = ov[i];
      tick();
    end
    bus_a.bram_en = 1'b0;
    tick();
    check("ovf_set", 64'(bus_a.overflow_err), 64'd1);
    check("ovf_data0", bus_a.tile_data, 64'h00000002_00000001);
    bus_a.tile_ready = 1'b1;
    tick();
    check("ovf_data1", bus_a.tile_data, 64'h00000004_00000003);
    tick();
    bus_a.tile_ready = 1'b0;
    check("ovf_count", 64'(bus_a.tile_count), 64'd5);
    check("ovf_sticky", 64'(bus_a.overflow_err), 64'd1);
    check("ovf_fill_ready", 64'(bus_a.fill_ready), 64'd1);
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    check("flush_ovf", 64'(bus_a.overflow_err), 64'd0);
    check("flush_count", 64'(bus_a.tile_count), 64'd0);

    // Flush mid-tile.
    bus_a.bram_en = 1'b1; rd_word = 32'h77;
    tick();
    bus_a.bram_en = 1'b0;
    tick();
    check("mid_fill_ready", 64'(bus_a.fill_ready), 64'd0);
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    check("mid_flush_fill_ready", 64'(bus_a.fill_ready), 64'd1);
    check("mid_flush_valid", 64'(bus_a.tile_valid), 64'd0);
    bus_a.bram_en = 1'b1; rd_word = 32'h55;
    tick();
    rd_word = 32'h66;
    tick();
    bus_a.bram_en = 1'b0;
    tick();
    check("mid_new_valid", 64'(bus_a.tile_valid), 64'd1);
    check("mid_new_data", bus_a.tile_data, 64'h00000066_00000055);
    bus_a.tile_ready = 1'b1;
    tick();
    bus_a.tile_ready = 1'b0;
    check("mid_count", 64'(bus_a.tile_count), 64'd1);

    // Reset while one bank is FULL and the other FILLING.
    bus_a.bram_en = 1'b1; rd_word = 32'hAA;
    tick();
    rd_word = 32'hBB;
    tick();
    rd_word = 32'hCC;
    tick();
    bus_a.bram_en = 1'b0;
    tick();
    check("rm_pre_valid", 64'(bus_a.tile_valid), 64'd1);
    check("rm_pre_fill_ready", 64'(bus_a.fill_ready), 64'd0);
    bus_a.tile_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus_a.tile_ready = 1'b0;
    check("rm_valid", 64'(bus_a.tile_valid), 64'd0);
    check("rm_count", 64'(bus_a.tile_count), 64'd0);
    check("rm_fill_ready", 64'(bus_a.fill_ready), 64'd1);
    check("rm_data", bus_a.tile_data, 64'd0);
    check("rm_ovf", 64'(bus_a.overflow_err), 64'd0);

    // READ_LATENCY=3 build.
    bus_b.bram_en = 1'b1; rd_word = 32'hC1;
    tick();
    check("l3_fill_ready_e1", 64'(bus_b.fill_ready), 64'd0);
    rd_word = 32'hD2;
    tick();
    bus_b.bram_en = 1'b0;
    rd_word = 32'h0;
    check("l3_fill_ready_e2", 64'(bus_b.fill_ready), 64'd0);
    tick();
    check("l3_no_capture_e3", bus_b.tile_data, 64'd0);
    check("l3_fill_ready_e3", 64'(bus_b.fill_ready), 64'd0);
    tick();
    check("l3_first_capture", bus_b.tile_data, 64'h00000000_000000C1);
    check("l3_valid_e4", 64'(bus_b.tile_valid), 64'd0);
    check("l3_fill_ready_e4", 64'(bus_b.fill_ready), 64'd0);
    tick();
    check("l3_valid", 64'(bus_b.tile_valid), 64'd1);
    check("l3_data", bus_b.tile_data, 64'h000000D2_000000C1);
    check("l3_fill_ready_idle", 64'(bus_b.fill_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
